// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pkg : shared constants and helpers for 7-segment display blocks |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package seg_pkg;

  typedef logic [0:0] scan_state_t;

  localparam logic [6:0]  SEG_BLANK_N = 7'h7F;
  localparam scan_state_t c_ST_BLANK  = 1'b0;
  localparam scan_state_t c_ST_SHOW   = 1'b1;

  // Bits needed for a down-counter that holds 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seven_seg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_to_seven_seg : 4-bit hex -> active-high segments (bit6=A..G)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hex_to_seven_seg (
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Seg
);

  always_comb begin
    o_Seg = 7'h00;
    unique case (i_Nibble)
      4'h0: o_Seg = 7'h7E;
      4'h1: o_Seg = 7'h30;
      4'h2: o_Seg = 7'h6D;
      4'h3: o_Seg = 7'h79;
      4'h4: o_Seg = 7'h33;
      4'h5: o_Seg = 7'h5B;
      4'h6: o_Seg = 7'h5F;
      4'h7: o_Seg = 7'h70;
      4'h8: o_Seg = 7'h7F;
      4'h9: o_Seg = 7'h7B;
      4'hA: o_Seg = 7'h77;
      4'hB: o_Seg = 7'h1F;
      4'hC: o_Seg = 7'h4E;
      4'hD: o_Seg = 7'h3D;
      4'hE: o_Seg = 7'h4F;
      4'hF: o_Seg = 7'h47;
      default: o_Seg = 7'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seven_seg_scan_ctrl : tear-free N-digit multiplexed display scanner |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int BLANK_CLKS     = 500
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Enable,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_Dp_Mask,
  input  logic                    i_Lz_Suppress,
  output logic [NUM_DIGITS-1:0]   o_Digit_Sel_n,
  output logic [6:0]              o_Segments_n,
  output logic                    o_Dp_n,
  output logic                    o_Frame_Done
);

  localparam int c_CNT_MAX = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int c_CW      = cnt_width(c_CNT_MAX);
  localparam int c_IW      = $clog2(NUM_DIGITS);

  localparam logic [c_CW-1:0] c_SHOW_LD  = c_CW'(CLKS_PER_DIGIT - 1);
  localparam logic [c_CW-1:0] c_BLANK_LD = c_CW'(BLANK_CLKS - 1);
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NUM_DIGITS - 1);

  scan_state_t             r_state_q,    w_state_d;
  logic [c_CW-1:0]         r_cnt_q,      w_cnt_d;
  logic [c_IW-1:0]         r_idx_q,      w_idx_d;
  logic [4*NUM_DIGITS-1:0] r_act_val_q,  w_act_val_d;
  logic [NUM_DIGITS-1:0]   r_act_dp_q,   w_act_dp_d;
  logic [4*NUM_DIGITS-1:0] r_pend_val_q, w_pend_val_d;
  logic [NUM_DIGITS-1:0]   r_pend_dp_q,  w_pend_dp_d;
  logic                    r_pend_vld_q, w_pend_vld_d;
  logic [NUM_DIGITS-1:0]   r_sel_q,      w_sel_d;
  logic [6:0]              r_seg_q,      w_seg_d;
  logic                    r_dp_q,       w_dp_d;
  logic                    r_fd_q,       w_fd_d;

  logic                    w_boundary;
  logic                    w_show;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_hi;
  logic [NUM_DIGITS-1:0]   w_zero_up;
  logic                    w_lz_blank;

  assign w_nib = r_act_val_q[{r_idx_q, 2'b00} +: 4];

  hex_to_seven_seg u_dec (
    .i_Nibble (w_nib),
    .o_Seg    (w_seg_hi)
  );

  // w_zero_up[k]: digit k and every digit above it are zero.
  always_comb begin : p_zero_up
    logic run;
    run       = 1'b1;
    w_zero_up = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run && (r_act_val_q[4*k +: 4] == 4'h0);
      w_zero_up[k] = run;
    end
  end

  assign w_lz_blank = i_Lz_Suppress && (r_idx_q != '0) && w_zero_up[r_idx_q];
  assign w_show     = i_Enable && (r_state_q == c_ST_SHOW);
  assign w_boundary = w_show && (r_cnt_q == '0) && (r_idx_q == c_LAST_IDX);

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_idx_d   = r_idx_q;
    if (!i_Enable) begin
      w_state_d = c_ST_BLANK;
      w_cnt_d   = c_BLANK_LD;
      w_idx_d   = '0;
    end else if (r_cnt_q != '0) begin
      w_cnt_d = r_cnt_q - 1'b1;
    end else if (r_state_q == c_ST_BLANK) begin
      w_state_d = c_ST_SHOW;
      w_cnt_d   = c_SHOW_LD;
    end else begin
      w_state_d = c_ST_BLANK;
      w_cnt_d   = c_BLANK_LD;
      w_idx_d   = (r_idx_q == c_LAST_IDX) ? '0 : r_idx_q + 1'b1;
    end
  end

  // Active only changes on a frame boundary so a frame never mixes two values.
  always_comb begin
    w_act_val_d  = r_act_val_q;
    w_act_dp_d   = r_act_dp_q;
    w_pend_val_d = r_pend_val_q;
    w_pend_dp_d  = r_pend_dp_q;
    w_pend_vld_d = r_pend_vld_q;
    if (w_boundary) begin
      if (i_Load) begin
        w_act_val_d = i_Value;
        w_act_dp_d  = i_Dp_Mask;
      end else if (r_pend_vld_q) begin
        w_act_val_d = r_pend_val_q;
        w_act_dp_d  = r_pend_dp_q;
      end
      w_pend_vld_d = 1'b0;
    end else if (i_Load) begin
      w_pend_val_d = i_Value;
      w_pend_dp_d  = i_Dp_Mask;
      w_pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    w_sel_d = '1;
    w_seg_d = SEG_BLANK_N;
    w_dp_d  = 1'b1;
    w_fd_d  = w_boundary;
    if (w_show) begin
      w_sel_d = ~(NUM_DIGITS'(1) << r_idx_q);
      w_seg_d = w_lz_blank ? SEG_BLANK_N : ~w_seg_hi;
      w_dp_d  = ~r_act_dp_q[r_idx_q];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state_q    <= c_ST_BLANK;
      r_cnt_q      <= c_BLANK_LD;
      r_idx_q      <= '0;
      r_act_val_q  <= '0;
      r_act_dp_q   <= '0;
      r_pend_val_q <= '0;
      r_pend_dp_q  <= '0;
      r_pend_vld_q <= 1'b0;
      r_sel_q      <= '1;
      r_seg_q      <= SEG_BLANK_N;
      r_dp_q       <= 1'b1;
      r_fd_q       <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_cnt_q      <= w_cnt_d;
      r_idx_q      <= w_idx_d;
      r_act_val_q  <= w_act_val_d;
      r_act_dp_q   <= w_act_dp_d;
      r_pend_val_q <= w_pend_val_d;
      r_pend_dp_q  <= w_pend_dp_d;
      r_pend_vld_q <= w_pend_vld_d;
      r_sel_q      <= w_sel_d;
      r_seg_q      <= w_seg_d;
      r_dp_q       <= w_dp_d;
      r_fd_q       <= w_fd_d;
    end
  end

  assign o_Digit_Sel_n = r_sel_q;
  assign o_Segments_n  = r_seg_q;
  assign o_Dp_n        = r_dp_q;
  assign o_Frame_Done  = r_fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seven_seg_scan_ctrl : directed frame-by-frame display checks    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_seven_seg_scan_ctrl;

  localparam int c_ND  = 4;
  localparam int c_CPD = 8;
  localparam int c_BC  = 2;
  localparam logic [12:0] c_DARK = {1'b0, 1'b1, 7'h7F, 4'hF};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        load  = 1'b0;
  logic        lz    = 1'b0;
  logic [15:0] val   = '0;
  logic [3:0]  dpm   = '0;
  logic [3:0]  sel_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        fd;

  int          n_vec = 0;
  int          n_err = 0;
  int          ld_off [2] = '{-1, -1};
  logic [15:0] ld_val [2];
  logic [3:0]  ld_dp  [2];

  seven_seg_scan_ctrl #(
    .NUM_DIGITS     (c_ND),
    .CLKS_PER_DIGIT (c_CPD),
    .BLANK_CLKS     (c_BC)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Enable      (en),
    .i_Load        (load),
    .i_Value       (val),
    .i_Dp_Mask     (dpm),
    .i_Lz_Suppress (lz),
    .o_Digit_Sel_n (sel_n),
    .o_Segments_n  (seg_n),
    .o_Dp_n        (dp_n),
    .o_Frame_Done  (fd)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] tbl(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  // Expected {fd, dp_n, seg_n, sel_n} at offset 1..40 after a frame start.
  function automatic logic [12:0] exp_at(input int off, input logic [15:0] v,
                                         input logic [3:0] m, input logic z);
    int          p;
    int          d;
    logic        blank;
    logic [12:0] r;
    p = (off - 1) % 10;
    d = (off - 1) / 10;
    r = {(off == 40), 1'b1, 7'h7F, 4'hF};
    if (p >= 2) begin
      blank    = z && (d != 0) && ((v >> (4 * d)) == 16'h0);
      r[3:0]   = ~(4'b0001 << d);
      r[10:4]  = blank ? 7'h7F : ~tbl(v[4*d +: 4]);
      r[11]    = ~m[d];
    end
    return r;
  endfunction

  function automatic logic [12:0] obs();
    return {fd, dp_n, seg_n, sel_n};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic wait_fd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = fd;
    end
    check("wait_fd", 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] v,
                             input logic [3:0] m, input logic z);
    for (int off = 1; off <= 40; off++) begin
      @(negedge clk);
      check($sformatf("%s_o%0d", tag, off), 32'(obs()), 32'(exp_at(off, v, m, z)));
      load = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (ld_off[j] == off) begin
          load = 1'b1;
          val  = ld_val[j];
          dpm  = ld_dp[j];
        end
      end
    end
    load   = 1'b0;
    ld_off = '{-1, -1};
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pins", 32'(obs()), 32'(c_DARK));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", 32'(obs()), 32'(c_DARK));
    load = 1'b1; val = 16'h12AF; dpm = 4'h0;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    wait_fd();

    ld_off = '{5, 20};
    ld_val = '{16'h0000, 16'h0042};
    ld_dp  = '{4'h0, 4'h0};
    check_frame("f12AF", 16'h12AF, 4'h0, 1'b0);
    check_frame("f0042", 16'h0042, 4'h0, 1'b0);

    lz     = 1'b1;
    ld_off = '{39, -1};
    ld_val = '{16'h0000, 16'h0000};
    ld_dp  = '{4'b0100, 4'h0};
    check_frame("lz0042", 16'h0042, 4'h0, 1'b1);
    check_frame("lz0000", 16'h0000, 4'b0100, 1'b1);

    lz = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_dis", 32'(obs()), 32'(exp_at(15, 16'h0000, 4'b0100, 1'b0)));
    en = 1'b0;
    @(negedge clk);
    check("dis_dark", 32'(obs()), 32'(c_DARK));
    load = 1'b1; val = 16'h3C07; dpm = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    check("dis_hold", 32'(obs()), 32'(c_DARK));
    en = 1'b1;
    check_frame("reen", 16'h0000, 4'b0100, 1'b0);
    check_frame("f3C07", 16'h3C07, 4'b0001, 1'b0);

    for (int off = 1; off <= 25; off++) begin
      @(negedge clk);
      load = (off == 22);
      if (off == 22) begin
        val = 16'h5555; dpm = 4'hF;
      end
    end
    check("pre_rst", 32'(obs()), 32'(exp_at(25, 16'h3C07, 4'b0001, 1'b0)));
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs()), 32'(c_DARK));
    repeat (2) @(negedge clk);
    check("rst_hold", 32'(obs()), 32'(c_DARK));
    rst_n = 1'b1;
    check_frame("post_rst", 16'h0000, 4'h0, 1'b0);
    check_frame("no_pend", 16'h0000, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
